// File: rtl/axi4_lite_buffered_write_slave_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) shared by the buffered write slave
// and whatever drives it.
//   master modport : drives AW/W payload and valids plus BREADY
//   slave  modport : drives AWREADY, WREADY, BVALID and BRESP
// STRB_WIDTH is derived from DATA_WIDTH so the strobe lane count cannot be
// set inconsistently.
interface axi4_lite_buffered_write_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0] S_AXI_WDATA;
  logic [STRB_WIDTH-1:0] S_AXI_WSTRB;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
  );
endinterface

// File: rtl/axi4_lite_buffered_write_slave.sv
// AXI4-Lite write slave with independent one-entry AW and W holding registers.
// A write commits once both holds are full and the B slot is free (or being
// drained on the same edge). The committed address is range/alignment checked:
// out of window -> DECERR, misaligned -> SLVERR, else OKAY plus a one-cycle
// registered mem_write pulse carrying the base-relative address.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   s_axi        : AXI4-Lite write channels (slave modport)
//   mem_write    : one-cycle write strobe to the local memory/register file
//   byte_en      : byte enables for mem_write
//   addr         : local address (AWADDR - ADDR_BASE)
//   write_data   : data for mem_write
//   err_count    : saturating count of non-OKAY responses
// addr/byte_en/write_data are only meaningful while mem_write is high.
module axi4_lite_buffered_write_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SIZE  = 32'h0000_1000
) (
  input  logic                       clk,
  input  logic                       rst,
  axi4_lite_buffered_write_slave_if.slave s_axi,
  output logic                       mem_write,
  output logic [DATA_WIDTH/8-1:0]    byte_en,
  output logic [ADDR_WIDTH-1:0]      addr,
  output logic [DATA_WIDTH-1:0]      write_data,
  output logic [7:0]                 err_count
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LSB_W      = $clog2(STRB_WIDTH);

  // Window bounds carry one extra bit so BASE+SIZE at the top of the address
  // space does not wrap to a small value.
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, ADDR_BASE};
  localparam logic [ADDR_WIDTH:0] WIN_HI = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  logic                  ready_en_q, ready_en_d;
  logic                  aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  resp_e                 bresp_q, bresp_d;
  logic                  mem_write_q, mem_write_d;
  logic [STRB_WIDTH-1:0] byte_en_q, byte_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic [7:0]            err_count_q, err_count_d;

  logic                  aw_hs, w_hs, commit;
  logic [ADDR_WIDTH:0]   aw_ext;
  resp_e                 resp;

  // Readies come straight from flops; a hold register cannot refill on its
  // own commit edge because ready is still low during that cycle.
  assign s_axi.S_AXI_AWREADY = ready_en_q & ~aw_full_q;
  assign s_axi.S_AXI_WREADY  = ready_en_q & ~w_full_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;

  assign aw_hs  = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
  assign w_hs   = s_axi.S_AXI_WVALID  & s_axi.S_AXI_WREADY;
  assign commit = aw_full_q & w_full_q & (~bvalid_q | s_axi.S_AXI_BREADY);
  assign aw_ext = {1'b0, awaddr_q};

  always_comb begin
    resp = RESP_OKAY;
    if (aw_ext < WIN_LO || aw_ext >= WIN_HI)
      resp = RESP_DECERR;
    else if (awaddr_q[LSB_W-1:0] != '0)
      resp = RESP_SLVERR;
  end

  always_comb begin
    ready_en_d   = 1'b1;
    aw_full_d    = aw_full_q;
    awaddr_d     = awaddr_q;
    w_full_d     = w_full_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    mem_write_d  = 1'b0;
    byte_en_d    = byte_en_q;
    addr_d       = addr_q;
    write_data_d = write_data_q;
    err_count_d  = err_count_q;

    // Handshake and commit are mutually exclusive per hold register:
    // a handshake needs it empty, a commit needs it full.
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
    if (aw_hs) begin
      aw_full_d = 1'b1;
      awaddr_d  = s_axi.S_AXI_AWADDR;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = s_axi.S_AXI_WDATA;
      wstrb_d  = s_axi.S_AXI_WSTRB;
    end

    // A commit on the B-handshake edge keeps BVALID high with the new response.
    if (bvalid_q && s_axi.S_AXI_BREADY)
      bvalid_d = 1'b0;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = resp;
      if (resp == RESP_OKAY) begin
        mem_write_d  = 1'b1;
        byte_en_d    = wstrb_q;
        addr_d       = awaddr_q - ADDR_BASE;
        write_data_d = wdata_q;
      end else if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_q   <= 1'b0;
      aw_full_q    <= 1'b0;
      awaddr_q     <= '0;
      w_full_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      mem_write_q  <= 1'b0;
      byte_en_q    <= '0;
      addr_q       <= '0;
      write_data_q <= '0;
      err_count_q  <= 8'd0;
    end else begin
      ready_en_q   <= ready_en_d;
      aw_full_q    <= aw_full_d;
      awaddr_q     <= awaddr_d;
      w_full_q     <= w_full_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      mem_write_q  <= mem_write_d;
      byte_en_q    <= byte_en_d;
      addr_q       <= addr_d;
      write_data_q <= write_data_d;
      err_count_q  <= err_count_d;
    end
  end

  assign mem_write  = mem_write_q;
  assign byte_en    = byte_en_q;
  assign addr       = addr_q;
  assign write_data = write_data_q;
  assign err_count  = err_count_q;
endmodule

// File: tb/tb_axi4_lite_buffered_write_slave.sv
module tb_axi4_lite_buffered_write_slave;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] SIZE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] exp_ec = 8'd0;

  // 32-bit instance
  logic        mw_a;
  logic [3:0]  be_a;
  logic [31:0] ad_a, wd_a;
  logic [7:0]  ec_a;
  axi4_lite_buffered_write_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
  axi4_lite_buffered_write_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ADDR_BASE(BASE), .ADDR_SIZE(SIZE)) dut_a (
    .clk(clk), .rst(rst), .s_axi(ifa), .mem_write(mw_a), .byte_en(be_a),
    .addr(ad_a), .write_data(wd_a), .err_count(ec_a));

  // 64-bit instance
  logic        mw_b;
  logic [7:0]  be_b;
  logic [31:0] ad_b;
  logic [63:0] wd_b;
  logic [7:0]  ec_b;
  axi4_lite_buffered_write_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) ifb ();
  axi4_lite_buffered_write_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ADDR_BASE(BASE), .ADDR_SIZE(SIZE)) dut_b (
    .clk(clk), .rst(rst), .s_axi(ifb), .mem_write(mw_b), .byte_en(be_b),
    .addr(ad_b), .write_data(wd_b), .err_count(ec_b));

  typedef struct { logic [31:0] a; logic [3:0] s; logic [31:0] d; int t; } mrec_t;
  mrec_t      mq[$];
  logic [1:0] bq[$];

  // Observed memory writes and B handshakes of the 32-bit instance.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (mw_a) mq.push_back('{a: ad_a, s: be_a, d: wd_a, t: cyc});
      if (ifa.S_AXI_BVALID && ifa.S_AXI_BREADY) bq.push_back(ifa.S_AXI_BRESP);
    end
  end

  // Reference: window / alignment rules evaluated with wide arithmetic.
  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    logic [63:0] ua, lo, hi;
    ua = {32'd0, a};
    lo = {32'd0, BASE};
    hi = {32'd0, BASE} + {32'd0, SIZE};
    if (ua < lo || ua >= hi) return 2'b11;
    if (ua % 4 != 0) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic aw_send(input logic [31:0] a, input int dly);
    logic hs;
    repeat (dly) step();
    ifa.S_AXI_AWADDR = a; ifa.S_AXI_AWVALID = 1'b1;
    hs = 1'b0;
    for (int k = 0; k < 200 && !hs; k++) begin hs = ifa.S_AXI_AWREADY; step(); end
    ifa.S_AXI_AWVALID = 1'b0;
    if (!hs) begin total++; bad++; $display("FAIL aw_timeout addr=%h no AWREADY within 200 cycles", a); end
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input int dly);
    logic hs;
    repeat (dly) step();
    ifa.S_AXI_WDATA = d; ifa.S_AXI_WSTRB = s; ifa.S_AXI_WVALID = 1'b1;
    hs = 1'b0;
    for (int k = 0; k < 200 && !hs; k++) begin hs = ifa.S_AXI_WREADY; step(); end
    ifa.S_AXI_WVALID = 1'b0;
    if (!hs) begin total++; bad++; $display("FAIL w_timeout data=%h no WREADY within 200 cycles", d); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY, ifa.S_AXI_BVALID, ifa.S_AXI_BRESP, mw_a, be_a, ad_a, wd_a, ec_a} !== '0) begin
      bad++; $display("FAIL reset_values got aw=%b w=%b bv=%b br=%b mw=%b be=%h ad=%h wd=%h ec=%h exp all 0",
        ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY, ifa.S_AXI_BVALID, ifa.S_AXI_BRESP, mw_a, be_a, ad_a, wd_a, ec_a);
    end
    rst = 1'b0;
    total++;
    if ({ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY} !== 2'b00) begin
      bad++; $display("FAIL ready_before_edge got=%b exp=00", {ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY});
    end
    step();
    total++;
    if ({ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY} !== 2'b11) begin
      bad++; $display("FAIL ready_release got=%b exp=11", {ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY});
    end
    exp_ec = 8'd0;
  endtask

  task automatic test_aligned();
    ifa.S_AXI_AWADDR = 32'h1008; ifa.S_AXI_AWVALID = 1'b1;
    ifa.S_AXI_WDATA = 32'hDEADBEEF; ifa.S_AXI_WSTRB = 4'hF; ifa.S_AXI_WVALID = 1'b1;
    step();
    ifa.S_AXI_AWVALID = 1'b0; ifa.S_AXI_WVALID = 1'b0;
    total++;
    if ({ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY, mw_a, ifa.S_AXI_BVALID} !== 4'b0000) begin
      bad++; $display("FAIL aligned_after_hs got aw/w/mw/bv=%b exp=0000", {ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY, mw_a, ifa.S_AXI_BVALID});
    end
    step();
    total++;
    if ({mw_a, ad_a, wd_a, be_a, ifa.S_AXI_BVALID, ifa.S_AXI_BRESP, ec_a} !== {1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 1'b1, 2'b00, 8'd0}) begin
      bad++; $display("FAIL aligned_commit got mw=%b ad=%h wd=%h be=%h bv=%b br=%b ec=%0d exp mw=1 ad=8 wd=deadbeef be=f bv=1 br=00 ec=0",
        mw_a, ad_a, wd_a, be_a, ifa.S_AXI_BVALID, ifa.S_AXI_BRESP, ec_a);
    end
    step();
    total++;
    if ({mw_a, ifa.S_AXI_BVALID} !== 2'b00) begin
      bad++; $display("FAIL aligned_pulse_end got mw/bv=%b exp=00", {mw_a, ifa.S_AXI_BVALID});
    end
  endtask

  task automatic test_staggered();
    w_send(32'hCAFE0123, 4'h5, 0);
    total++;
    if (ifa.S_AXI_WREADY !== 1'b0) begin bad++; $display("FAIL stagger_wready got=%b exp=0", ifa.S_AXI_WREADY); end
    repeat (2) begin
      step();
      total++;
      if ({ifa.S_AXI_WREADY, mw_a, ifa.S_AXI_BVALID} !== 3'b000) begin
        bad++; $display("FAIL stagger_wait got wr/mw/bv=%b exp=000", {ifa.S_AXI_WREADY, mw_a, ifa.S_AXI_BVALID});
      end
    end
    aw_send(32'h1ffc, 0);
    total++;
    if ({mw_a, ifa.S_AXI_BVALID} !== 2'b00) begin bad++; $display("FAIL stagger_early got mw/bv=%b exp=00", {mw_a, ifa.S_AXI_BVALID}); end
    step();
    total++;
    if ({mw_a, ad_a, wd_a, be_a, ifa.S_AXI_BVALID, ifa.S_AXI_BRESP} !== {1'b1, 32'hffc, 32'hCAFE0123, 4'h5, 1'b1, 2'b00}) begin
      bad++; $display("FAIL stagger_commit got mw=%b ad=%h wd=%h be=%h bv=%b br=%b exp mw=1 ad=ffc wd=cafe0123 be=5 bv=1 br=00",
        mw_a, ad_a, wd_a, be_a, ifa.S_AXI_BVALID, ifa.S_AXI_BRESP);
    end
    step();
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3];
    addrs[0] = 32'h2000; addrs[1] = 32'h1002; addrs[2] = 32'h0ffc;
    for (int i = 0; i < 3; i++) begin
      fork
        aw_send(addrs[i], 0);
        w_send($urandom, 4'hF, 0);
      join
      if (exp_resp(addrs[i]) != 2'b00) exp_ec = sat_inc(exp_ec);
      step();
      total++;
      if ({ifa.S_AXI_BVALID, ifa.S_AXI_BRESP, mw_a, ec_a} !== {1'b1, exp_resp(addrs[i]), 1'b0, exp_ec}) begin
        bad++; $display("FAIL error_resp addr=%h got bv=%b br=%b mw=%b ec=%0d exp bv=1 br=%b mw=0 ec=%0d",
          addrs[i], ifa.S_AXI_BVALID, ifa.S_AXI_BRESP, mw_a, ec_a, exp_resp(addrs[i]), exp_ec);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    ifa.S_AXI_BREADY = 1'b0;
    fork aw_send(32'h1010, 0); w_send(32'h11111111, 4'hF, 0); join
    step();
    total++;
    if ({mw_a, ifa.S_AXI_BVALID, ad_a} !== {1'b1, 1'b1, 32'h10}) begin
      bad++; $display("FAIL bp_first got mw=%b bv=%b ad=%h exp mw=1 bv=1 ad=10", mw_a, ifa.S_AXI_BVALID, ad_a);
    end
    fork aw_send(32'h1020, 0); w_send(32'h22222222, 4'h3, 0); join
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY, ifa.S_AXI_BVALID, mw_a} !== 4'b0010) begin
        bad++; $display("FAIL bp_hold cycle=%0d got aw/w/bv/mw=%b exp=0010", i, {ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY, ifa.S_AXI_BVALID, mw_a});
      end
      if (i < 3) step();
    end
    ifa.S_AXI_BREADY = 1'b1;
    step();
    total++;
    if ({mw_a, ad_a, wd_a, be_a, ifa.S_AXI_BVALID, ifa.S_AXI_BRESP} !== {1'b1, 32'h20, 32'h22222222, 4'h3, 1'b1, 2'b00}) begin
      bad++; $display("FAIL bp_second got mw=%b ad=%h wd=%h be=%h bv=%b br=%b exp mw=1 ad=20 wd=22222222 be=3 bv=1 br=00",
        mw_a, ad_a, wd_a, be_a, ifa.S_AXI_BVALID, ifa.S_AXI_BRESP);
    end
    step();
    total++;
    if ({mw_a, ifa.S_AXI_BVALID} !== 2'b00) begin bad++; $display("FAIL bp_drain got mw/bv=%b exp=00", {mw_a, ifa.S_AXI_BVALID}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] dat [6];
    for (int i = 0; i < 6; i++) dat[i] = $urandom;
    mq.delete();
    fork
      for (int i = 0; i < 6; i++) aw_send(BASE + 32'(i * 4), 0);
      for (int i = 0; i < 6; i++) w_send(dat[i], 4'hF, 0);
    join
    repeat (4) step();
    total++;
    if (mq.size() != 6) begin
      bad++; $display("FAIL b2b_count got=%0d exp=6", mq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (mq[i].a !== 32'(i * 4) || mq[i].d !== dat[i] || (i > 0 && mq[i].t - mq[i-1].t != 2)) begin
          bad++; $display("FAIL b2b_write idx=%0d got ad=%h wd=%h gap=%0d exp ad=%h wd=%h gap=2",
            i, mq[i].a, mq[i].d, (i > 0) ? mq[i].t - mq[i-1].t : 2, 32'(i * 4), dat[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    mrec_t      em[$];
    logic [1:0] eb[$];
    logic [31:0] edges [4];
    bit done;
    edges[0] = BASE - 32'd4; edges[1] = BASE + SIZE; edges[2] = BASE + SIZE - 32'd4; edges[3] = 32'hFFFF_FFFC;
    mq.delete(); bq.delete();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] a, d;
          logic [3:0]  s;
          case ($urandom_range(0, 3))
            0, 1:    a = BASE + 32'($urandom_range(0, 1023) * 4);
            2:       a = BASE + 32'($urandom_range(0, 4095));
            default: a = edges[$urandom_range(0, 3)];
          endcase
          d = $urandom; s = 4'($urandom);
          eb.push_back(exp_resp(a));
          if (exp_resp(a) == 2'b00) em.push_back('{a: a - BASE, s: s, d: d, t: 0});
          else exp_ec = sat_inc(exp_ec);
          fork
            aw_send(a, $urandom_range(0, 3));
            w_send(d, s, $urandom_range(0, 3));
          join
        end
        done = 1'b1;
      end
      while (!done) begin
        step();
        ifa.S_AXI_BREADY = ($urandom_range(0, 3) != 0);
      end
    join
    ifa.S_AXI_BREADY = 1'b1;
    repeat (6) step();
    total++;
    if (bq.size() != eb.size() || mq.size() != em.size()) begin
      bad++; $display("FAIL rand_counts got b=%0d m=%0d exp b=%0d m=%0d", bq.size(), mq.size(), eb.size(), em.size());
    end else begin
      for (int i = 0; i < eb.size(); i++) begin
        total++;
        if (bq[i] !== eb[i]) begin bad++; $display("FAIL rand_bresp idx=%0d got=%b exp=%b", i, bq[i], eb[i]); end
      end
      for (int i = 0; i < em.size(); i++) begin
        total++;
        if (mq[i].a !== em[i].a || mq[i].s !== em[i].s || mq[i].d !== em[i].d) begin
          bad++; $display("FAIL rand_mem idx=%0d got ad=%h be=%h wd=%h exp ad=%h be=%h wd=%h",
            i, mq[i].a, mq[i].s, mq[i].d, em[i].a, em[i].s, em[i].d);
        end
      end
    end
    total++;
    if (ec_a !== exp_ec) begin bad++; $display("FAIL rand_errcount got=%0d exp=%0d", ec_a, exp_ec); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) begin
      fork aw_send(32'h0000_0000, 0); w_send(32'h0, 4'hF, 0); join
      exp_ec = sat_inc(exp_ec);
    end
    repeat (3) step();
    total++;
    if (ec_a !== 8'hFF || exp_ec !== 8'hFF) begin bad++; $display("FAIL err_saturate got=%h exp=ff", ec_a); end
  endtask

  task automatic test_wide();
    logic [63:0] d;
    d = {$urandom, $urandom};
    total++;
    if (ifb.S_AXI_AWREADY !== 1'b1) begin bad++; $display("FAIL wide_ready got=%b exp=1", ifb.S_AXI_AWREADY); end
    ifb.S_AXI_AWADDR = 32'h1008; ifb.S_AXI_AWVALID = 1'b1;
    ifb.S_AXI_WDATA = d; ifb.S_AXI_WSTRB = 8'hF0; ifb.S_AXI_WVALID = 1'b1;
    step();
    ifb.S_AXI_AWVALID = 1'b0; ifb.S_AXI_WVALID = 1'b0;
    step();
    total++;
    if ({mw_b, be_b, ad_b, wd_b, ifb.S_AXI_BVALID, ifb.S_AXI_BRESP} !== {1'b1, 8'hF0, 32'h8, d, 1'b1, 2'b00}) begin
      bad++; $display("FAIL wide_ok got mw=%b be=%h ad=%h wd=%h bv=%b br=%b exp mw=1 be=f0 ad=8 wd=%h bv=1 br=00",
        mw_b, be_b, ad_b, wd_b, ifb.S_AXI_BVALID, ifb.S_AXI_BRESP, d);
    end
    ifb.S_AXI_AWADDR = 32'h1004; ifb.S_AXI_AWVALID = 1'b1; ifb.S_AXI_WVALID = 1'b1;
    step();
    ifb.S_AXI_AWVALID = 1'b0; ifb.S_AXI_WVALID = 1'b0;
    step();
    total++;
    if ({mw_b, ifb.S_AXI_BVALID, ifb.S_AXI_BRESP, ec_b} !== {1'b0, 1'b1, 2'b10, 8'd1}) begin
      bad++; $display("FAIL wide_slverr got mw=%b bv=%b br=%b ec=%0d exp mw=0 bv=1 br=10 ec=1", mw_b, ifb.S_AXI_BVALID, ifb.S_AXI_BRESP, ec_b);
    end
    step();
  endtask

  task automatic test_reset_mid();
    ifa.S_AXI_BREADY = 1'b0;
    fork aw_send(32'h1040, 0); w_send(32'h44444444, 4'hF, 0); join
    step();
    aw_send(32'h1044, 0);
    total++;
    if ({ifa.S_AXI_BVALID, ifa.S_AXI_AWREADY} !== 2'b10) begin
      bad++; $display("FAIL mid_setup got bv/awready=%b exp=10", {ifa.S_AXI_BVALID, ifa.S_AXI_AWREADY});
    end
    rst = 1'b1;
    #1;
    total++;
    if ({ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY, ifa.S_AXI_BVALID, ifa.S_AXI_BRESP, mw_a, be_a, ad_a, wd_a, ec_a, mw_b, ec_b, ifb.S_AXI_BVALID} !== '0) begin
      bad++; $display("FAIL mid_reset_values got aw=%b w=%b bv=%b br=%b mw=%b be=%h ad=%h wd=%h ec=%h exp all 0",
        ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY, ifa.S_AXI_BVALID, ifa.S_AXI_BRESP, mw_a, be_a, ad_a, wd_a, ec_a);
    end
    exp_ec = 8'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    ifa.S_AXI_BREADY = 1'b1;
    mq.delete(); bq.delete();
    repeat (10) step();
    total++;
    if (mq.size() != 0 || bq.size() != 0 || ifa.S_AXI_AWREADY !== 1'b1) begin
      bad++; $display("FAIL mid_no_spurious got mem=%0d b=%0d awready=%b exp mem=0 b=0 awready=1", mq.size(), bq.size(), ifa.S_AXI_AWREADY);
    end
  endtask

  initial begin
    ifa.S_AXI_AWADDR = '0; ifa.S_AXI_AWVALID = 1'b0; ifa.S_AXI_WDATA = '0;
    ifa.S_AXI_WSTRB = '0; ifa.S_AXI_WVALID = 1'b0; ifa.S_AXI_BREADY = 1'b1;
    ifb.S_AXI_AWADDR = '0; ifb.S_AXI_AWVALID = 1'b0; ifb.S_AXI_WDATA = '0;
    ifb.S_AXI_WSTRB = '0; ifb.S_AXI_WVALID = 1'b0; ifb.S_AXI_BREADY = 1'b1;
    test_reset();
    test_aligned();
    test_staggered();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_wide();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
